// File: rtl/acc_core_pkg.sv
// Shared opcode/state encodings and field-width helpers for the acc_core accumulator machine.
package acc_core_pkg;

  localparam int OP_BITS = 5;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_LDR  = 5'h01,
    OP_STR  = 5'h02,
    OP_ADD  = 5'h03,
    OP_ADC  = 5'h04,
    OP_SUB  = 5'h05,
    OP_AND  = 5'h06,
    OP_OR   = 5'h07,
    OP_XOR  = 5'h08,
    OP_SHL  = 5'h09,
    OP_SHR  = 5'h0A,
    OP_LDI  = 5'h0B,
    OP_CLO  = 5'h0C,
    OP_LDM  = 5'h0D,
    OP_STM  = 5'h0E,
    OP_BZ   = 5'h0F,
    OP_BOV  = 5'h10,
    OP_HALT = 5'h1F
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_e;

  // Register-select width; a single-register file still needs one select bit.
  function automatic int reg_bits(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int instr_bits(input int nreg);
    return OP_BITS + reg_bits(nreg);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: computes the accumulator/flag result of one instruction plus write enables.
module acc_alu
  import acc_core_pkg::*;
#(
  parameter int DW = 8,
  parameter int RW = 4
) (
  input  logic [4:0]    op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  logic          ovf_in,
  input  logic [RW-1:0] r,
  output logic [DW-1:0] result,
  output logic          ovf_out,
  output logic          acc_we,
  output logic          ovf_we
);

  logic [DW:0] wide;

  always_comb begin
    // NOTE: every output gets a default before the case so no opcode path can infer a latch.
    result  = '0;
    ovf_out = ovf_in;
    acc_we  = 1'b0;
    ovf_we  = 1'b0;
    wide    = '0;
    case (op)
      OP_LDR: begin
        result = operand;
        acc_we = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        wide    = {1'b0, acc} + {1'b0, operand} + {{DW{1'b0}}, ovf_in & (op == OP_ADC)};
        result  = wide[DW-1:0];
        ovf_out = wide[DW];
        acc_we  = 1'b1;
        ovf_we  = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        wide    = {1'b0, acc} - {1'b0, operand};
        result  = wide[DW-1:0];
        ovf_out = wide[DW];
        acc_we  = 1'b1;
        ovf_we  = 1'b1;
      end
      OP_AND: begin result = acc & operand; acc_we = 1'b1; end
      OP_OR:  begin result = acc | operand; acc_we = 1'b1; end
      OP_XOR: begin result = acc ^ operand; acc_we = 1'b1; end
      OP_SHL: begin
        result  = {acc[DW-2:0], 1'b0};
        ovf_out = acc[DW-1];
        acc_we  = 1'b1;
        ovf_we  = 1'b1;
      end
      OP_SHR: begin
        // Rotate right through the flag.
        result  = {ovf_in, acc[DW-1:1]};
        ovf_out = acc[0];
        acc_we  = 1'b1;
        ovf_we  = 1'b1;
      end
      OP_LDI: begin
        result = DW'(r);
        acc_we = 1'b1;
      end
      OP_CLO: begin
        ovf_out = 1'b0;
        ovf_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALTED sequencer, register file, PC and counters.
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int PCW  = 8,
  parameter int CW   = 16,
  localparam int RW  = reg_bits(NREG),
  localparam int IW  = instr_bits(NREG)
) (
  input  logic           CLK,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic           Halt,
  output logic           ovf,
  output logic [DW-1:0]  acc_out,
  output logic [CW-1:0]  cycle_ct,
  output logic [CW-1:0]  instr_ct
);

  state_e         state;
  logic [PCW-1:0] pc;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  regs [NREG];

  logic [4:0]     op;
  logic [RW-1:0]  rsel;
  logic [DW-1:0]  operand;
  logic           is_mem;
  logic           taken;
  logic           retire;
  logic [PCW-1:0] next_pc;

  logic [DW-1:0]  alu_result;
  logic           alu_ovf;
  logic           alu_acc_we;
  logic           alu_ovf_we;

  // The instruction word is held stable through EXEC and MEM, so decode straight from it.
  assign op      = imem_data[IW-1:RW];
  assign rsel    = imem_data[RW-1:0];
  assign operand = regs[rsel];
  assign is_mem  = (op == OP_LDM) || (op == OP_STM);
  assign taken   = ((op == OP_BZ) && (acc == '0)) || ((op == OP_BOV) && ovf);
  assign next_pc = taken ? operand[PCW-1:0] : pc + 1'b1;
  assign retire  = ((state == S_EXEC) && !is_mem) || ((state == S_MEM) && dmem_ack);

  acc_alu #(.DW(DW), .RW(RW)) u_alu (
    .op      (op),
    .acc     (acc),
    .operand (operand),
    .ovf_in  (ovf),
    .r       (rsel),
    .result  (alu_result),
    .ovf_out (alu_ovf),
    .acc_we  (alu_acc_we),
    .ovf_we  (alu_ovf_we)
  );

  always_ff @(posedge CLK) begin
    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (start) begin
      state      <= S_FETCH;
      pc         <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cycle_ct   <= '0;
      instr_ct   <= '0;
      // NOTE: the register file is architecturally cleared by start, so it is built from flops.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if ((state != S_HALTED) && (cycle_ct != '1)) cycle_ct <= cycle_ct + 1'b1;

      if (retire) begin
        pc <= next_pc;
        if (instr_ct != '1) instr_ct <= instr_ct + 1'b1;
      end

      unique case (state)
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (alu_acc_we) acc <= alu_result;
          if (alu_ovf_we) ovf <= alu_ovf;
          if (op == OP_STR) regs[rsel] <= acc;
          if (is_mem) begin
            dmem_addr  <= operand;
            dmem_we    <= (op == OP_STM);
            dmem_wdata <= acc;
            state      <= S_MEM;
          end else begin
            state <= (op == OP_HALT) ? S_HALTED : S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (!dmem_we) acc <= dmem_rdata;
            state <= S_FETCH;
          end
        end
        S_HALTED: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign dmem_req  = (state == S_MEM);
  assign Halt      = (state == S_HALTED);
  assign acc_out   = acc;

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: directed programs plus random programs checked against an ISA-level interpreter.
module tb_acc_core;

  localparam int DW   = 8;
  localparam int NREG = 16;
  localparam int PCW  = 8;
  localparam int CW   = 16;
  localparam int RW   = $clog2(NREG);
  localparam int IW   = 5 + RW;
  localparam int MASK = (1 << DW) - 1;
  localparam int PCN  = 1 << PCW;

  localparam int O_NOP = 0, O_LDR = 1, O_STR = 2, O_ADD = 3, O_ADC = 4, O_SUB = 5;
  localparam int O_AND = 6, O_OR = 7, O_XOR = 8, O_SHL = 9, O_SHR = 10, O_LDI = 11;
  localparam int O_CLO = 12, O_LDM = 13, O_STM = 14, O_BZ = 15, O_BOV = 16, O_HALT = 31;

  logic           CLK = 1'b0;
  logic           start;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic           dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic           Halt, ovf;
  logic [DW-1:0]  acc_out;
  logic [CW-1:0]  cycle_ct, instr_ct;

  acc_core #(.DW(DW), .NREG(NREG), .PCW(PCW), .CW(CW)) dut (
    .CLK        (CLK),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .Halt       (Halt),
    .ovf        (ovf),
    .acc_out    (acc_out),
    .cycle_ct   (cycle_ct),
    .instr_ct   (instr_ct)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory: data valid the cycle after the address.
  logic [IW-1:0] imem [PCN];
  always @(posedge CLK) imem_data <= imem[imem_addr];

  logic [DW-1:0] bmem [1 << DW];

  typedef struct {int pc; int acc; int ovf; int cyc; int n;} ret_t;
  typedef struct {int addr; int we; int wdata; int cnt; bit stable;} req_t;

  ret_t exp_q[$];
  req_t req_log[$];
  int   lat_list[$];
  int   exp_n, exp_cyc;
  bit   exp_halt;
  int   prog_n;
  int   mem_wait, lat_cur, resp_idx;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < PCN; i++) imem[i] = '0;
    prog_n = 0;
    lat_list.delete();
  endtask

  task automatic emit(input int op, input int r);
    imem[prog_n] = {op[4:0], r[RW-1:0]};
    prog_n++;
  endtask

  task automatic do_reset();
    start    = 1'b1;
    dmem_ack = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    start    = 1'b0;
    mem_wait = 0;
    resp_idx = 0;
    req_log.delete();
  endtask

  // Instruction-level interpreter: one loop iteration per retired instruction.
  task automatic model_run(input int limit);
    int  rf[NREG];
    int  mm[1 << DW];
    int  lq[$];
    int  acc, fl, pc, cyc, n, op, r, v, npc, lat, t;
    bit  halted;
    acc = 0; fl = 0; pc = 0; cyc = 0; n = 0; halted = 0;
    for (int i = 0; i < NREG; i++) rf[i] = 0;
    for (int i = 0; i < (1 << DW); i++) mm[i] = int'(bmem[i]);
    lq = lat_list;
    exp_q.delete();
    while (!halted && n < limit) begin
      op  = int'(imem[pc][IW-1:RW]);
      r   = int'(imem[pc][RW-1:0]);
      v   = rf[r];
      npc = (pc + 1) % PCN;
      cyc += 2;
      case (op)
        O_LDR: acc = v;
        O_STR: rf[r] = acc;
        O_ADD: begin acc = acc + v; fl = acc >> DW; acc &= MASK; end
        O_ADC: begin acc = acc + v + fl; fl = acc >> DW; acc &= MASK; end
        O_SUB: begin fl = (acc < v) ? 1 : 0; acc = (acc - v) & MASK; end
        O_AND: acc = acc & v;
        O_OR:  acc = acc | v;
        O_XOR: acc = acc ^ v;
        O_SHL: begin fl = (acc >> (DW - 1)) & 1; acc = (acc << 1) & MASK; end
        O_SHR: begin t = acc & 1; acc = (acc >> 1) | (fl << (DW - 1)); fl = t; end
        O_LDI: acc = r;
        O_CLO: fl = 0;
        O_LDM, O_STM: begin
          lat = (lq.size() > 0) ? lq.pop_front() : 1;
          cyc += lat;
          if (op == O_LDM) acc = mm[v];
          else mm[v] = acc;
        end
        O_BZ:   if (acc == 0) npc = v % PCN;
        O_BOV:  if (fl != 0) npc = v % PCN;
        O_HALT: halted = 1;
        default: ;
      endcase
      pc = npc;
      n++;
      exp_q.push_back('{pc: pc, acc: acc, ovf: fl, cyc: cyc, n: n});
    end
    exp_n    = n;
    exp_cyc  = cyc;
    exp_halt = halted;
  endtask

  // Data-memory responder, called #1 after each rising edge.
  task automatic respond();
    if (dmem_req) begin
      if (mem_wait == 0) begin
        lat_cur = (resp_idx < lat_list.size()) ? lat_list[resp_idx] : 1;
        resp_idx++;
        req_log.push_back('{addr: int'(dmem_addr), we: int'(dmem_we), wdata: int'(dmem_wdata), cnt: 0, stable: 1'b1});
      end
      mem_wait++;
      req_log[req_log.size()-1].cnt++;
      if (int'(dmem_addr) != req_log[req_log.size()-1].addr || int'(dmem_we) != req_log[req_log.size()-1].we ||
          int'(dmem_wdata) != req_log[req_log.size()-1].wdata)
        req_log[req_log.size()-1].stable = 1'b0;
      if (mem_wait >= lat_cur) begin
        dmem_ack   = 1'b1;
        dmem_rdata = bmem[dmem_addr];
        if (dmem_we) bmem[dmem_addr] = dmem_wdata;
        mem_wait   = 0;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = DW'($urandom);
      end
    end else begin
      dmem_ack = 1'b0;
      mem_wait = 0;
    end
  endtask

  // Reset, then run until the model's retirement count is reached, checking every retirement.
  task automatic run_prog(input int limit);
    ret_t e;
    int   prev, budget;
    model_run(limit);
    do_reset();
    prev   = 0;
    budget = exp_cyc + 50;
    for (int c = 0; c < budget; c++) begin
      @(posedge CLK);
      #1;
      respond();
      if (int'(instr_ct) != prev) begin
        prev = int'(instr_ct);
        check("retire_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("retire_n", instr_ct, e.n);
          check("retire_pc", imem_addr, e.pc);
          check("retire_acc", acc_out, e.acc);
          check("retire_ovf", ovf, e.ovf);
          check("retire_cyc", cycle_ct, e.cyc);
        end
      end
      if (int'(instr_ct) == exp_n && (!exp_halt || Halt)) break;
    end
    dmem_ack = 1'b0;
    check("run_instr", instr_ct, exp_n);
    check("run_cycles", cycle_ct, exp_cyc);
    check("run_halt", Halt, exp_halt);
  endtask

  initial begin
    int sel, op;
    start      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    for (int i = 0; i < (1 << DW); i++) bmem[i] = '0;

    // Reset state
    clear_prog();
    do_reset();
    check("rst_halt", Halt, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_cycle_ct", cycle_ct, 0);
    check("rst_instr_ct", instr_ct, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", ovf, 0);

    // LDI 5; STR R1; LDI 7; ADD R1; HALT
    clear_prog();
    emit(O_LDI, 5); emit(O_STR, 1); emit(O_LDI, 7); emit(O_ADD, 1); emit(O_HALT, 0);
    run_prog(100);
    check("p1_acc", acc_out, 8'h0C);
    check("p1_ovf", ovf, 0);
    check("p1_instr", instr_ct, 5);
    check("p1_cycles", cycle_ct, 10);
    check("p1_halt", Halt, 1);
    repeat (4) @(posedge CLK);
    #1;
    check("p1_halt_held", Halt, 1);
    check("p1_cycles_frozen", cycle_ct, 10);

    // 0xF0 + 0x20 -> 0x10 with carry
    clear_prog();
    emit(O_LDI, 1); repeat (5) emit(O_SHL, 0); emit(O_STR, 2);
    emit(O_LDI, 15); repeat (4) emit(O_SHL, 0); emit(O_ADD, 2); emit(O_HALT, 0);
    run_prog(100);
    check("add_carry_acc", acc_out, 8'h10);
    check("add_carry_ovf", ovf, 1);

    // Same, followed by ADC R0
    clear_prog();
    emit(O_LDI, 1); repeat (5) emit(O_SHL, 0); emit(O_STR, 2);
    emit(O_LDI, 15); repeat (4) emit(O_SHL, 0); emit(O_ADD, 2); emit(O_ADC, 0); emit(O_HALT, 0);
    run_prog(100);
    check("adc_acc", acc_out, 8'h11);
    check("adc_ovf", ovf, 0);

    // STM with a 3-cycle wait, then LDM acked in its first MEM cycle
    clear_prog();
    emit(O_LDI, 1); repeat (6) emit(O_SHL, 0); emit(O_STR, 3);
    emit(O_LDI, 10); repeat (4) emit(O_SHL, 0); emit(O_STR, 6);
    emit(O_LDI, 5); emit(O_OR, 6); emit(O_STM, 3); emit(O_LDM, 7); emit(O_HALT, 0);
    lat_list.push_back(3);
    lat_list.push_back(1);
    bmem[0] = 8'h5A;
    run_prog(100);
    check("mem_req_count", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      check("stm_req_cycles", req_log[0].cnt, 3);
      check("stm_addr", req_log[0].addr, 8'h40);
      check("stm_wdata", req_log[0].wdata, 8'hA5);
      check("stm_we", req_log[0].we, 1);
      check("stm_stable", req_log[0].stable, 1);
      check("ldm_req_cycles", req_log[1].cnt, 1);
      check("ldm_we", req_log[1].we, 0);
    end
    check("stored_value", bmem[8'h40], 8'hA5);
    check("ldm_acc", acc_out, 8'h5A);
    check("mem_total_cycles", cycle_ct, 42);

    // BZ taken: ACC = 0, R4 = 0x20
    clear_prog();
    emit(O_LDI, 1); repeat (5) emit(O_SHL, 0); emit(O_STR, 4);
    emit(O_LDI, 0); emit(O_BZ, 4); emit(O_HALT, 0);
    prog_n = 32;
    emit(O_HALT, 0);
    run_prog(100);
    check("bz_taken_pc", imem_addr, 8'h21);
    check("bz_taken_instr", instr_ct, 10);

    // BZ not taken: ACC = 1
    clear_prog();
    emit(O_LDI, 1); repeat (5) emit(O_SHL, 0); emit(O_STR, 4);
    emit(O_LDI, 1); emit(O_BZ, 4); emit(O_HALT, 0);
    prog_n = 32;
    emit(O_HALT, 0);
    run_prog(100);
    check("bz_fall_pc", imem_addr, 8'h0A);
    check("bz_fall_instr", instr_ct, 10);

    // Branch to 0xFF, NOP there wraps the fetch address to 0
    clear_prog();
    emit(O_LDI, 15); repeat (4) emit(O_SHL, 0); emit(O_STR, 8);
    emit(O_LDI, 15); emit(O_OR, 8); emit(O_STR, 9); emit(O_LDI, 0); emit(O_BZ, 9);
    run_prog(12);
    check("wrap_pc", imem_addr, 0);
    check("wrap_instr", instr_ct, 12);

    // start and ack together in the second MEM cycle of a load
    clear_prog();
    emit(O_LDM, 0);
    bmem[0] = 8'h77;
    do_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("abort_req_mem1", dmem_req, 1);
    @(posedge CLK); #1;
    check("abort_req_mem2", dmem_req, 1);
    start      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 8'h77;
    @(posedge CLK); #1;
    start    = 1'b0;
    dmem_ack = 1'b0;
    check("abort_acc", acc_out, 0);
    check("abort_instr", instr_ct, 0);
    check("abort_req_drop", dmem_req, 0);
    check("abort_pc", imem_addr, 0);
    check("abort_cycles", cycle_ct, 0);
    @(posedge CLK); #1;
    check("abort_refetch_pc", imem_addr, 0);
    check("abort_not_halted", Halt, 0);

    // Random programs against the interpreter
    for (int t = 0; t < 4; t++) begin
      clear_prog();
      for (int a = 0; a < PCN; a++) begin
        sel = $urandom_range(0, 99);
        if (sel < 3) op = O_HALT;
        else if (sel < 8) op = $urandom_range(17, 30);
        else op = $urandom_range(0, 16);
        imem[a] = {op[4:0], RW'($urandom)};
      end
      for (int i = 0; i < (1 << DW); i++) bmem[i] = DW'($urandom);
      for (int i = 0; i < 40; i++) lat_list.push_back($urandom_range(1, 4));
      run_prog(60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_core.md
# acc_core

Parametrised multi-cycle accumulator processor core, the next generation of the team's 8-bit accumulator machine. It generalises data width, register count and PC width. It adds an external instruction-memory port, a variable-latency req/ack data-memory port, a working sticky overflow/carry flag, taken-branch control, and retired-instruction plus cycle counters. It sits under the chip top level in place of the previous hard-wired datapath.

## Interface
- DW, 8: data/accumulator/register width; also data address width.
- NREG, 16: register count (power of 2); RW = $clog2(NREG); instruction width IW = 5 + RW.
- PCW, 8: program counter width.
- CW, 16: counter width.
- CLK  in  1  sole clock; all state updates on rising edge.
- start  in  1  reset: synchronous, active-high; also restarts a halted core.
- imem_addr  out  PCW  fetch address (= PC).
- imem_data  in  IW  instruction; synchronous memory, valid the cycle after imem_addr.
- dmem_req  out  1  data request, held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid with req.
- dmem_addr  out  DW  data address; valid with req.
- dmem_wdata  out  DW  store data; valid with req.
- dmem_rdata  in  DW  load data; sampled with ack.
- dmem_ack  in  1  transfer complete; honoured only while dmem_req = 1.
- Halt  out  1  core stopped.
- ovf  out  1  overflow/carry flag.
- acc_out  out  DW  accumulator value (debug).
- cycle_ct  out  CW  active cycles.
- instr_ct  out  CW  retired instructions.

## Operation
- Instruction fields: op = imem_data[IW-1:RW] (5 bits); r = imem_data[RW-1:0]. R[r] is register r.
- Opcodes:
  - 00 NOP.
  - 01 LDR: ACC = R[r].
  - 02 STR: R[r] = ACC.
  - 03 ADD: {ovf,ACC} = ACC + R[r].
  - 04 ADC: {ovf,ACC} = ACC + R[r] + ovf.
  - 05 SUB: ACC = ACC - R[r]; ovf = borrow.
  - 06 AND, 07 OR, 08 XOR: ACC = ACC op R[r]; ovf unchanged.
  - 09 SHL: {ovf,ACC} = {ACC,1'b0}.
  - 0A SHR: {ACC,ovf} = {ovf,ACC}.
  - 0B LDI: ACC = zero-extended r.
  - 0C CLO: ovf = 0.
  - 0D LDM: ACC = mem[R[r]].
  - 0E STM: mem[R[r]] = ACC.
  - 0F BZ: if ACC == 0, PC = R[r][PCW-1:0].
  - 10 BOV: if ovf, PC = R[r][PCW-1:0].
  - 1F HALT.
  - All other opcodes execute as NOP.
- Arithmetic is modulo 2^DW. The carry-out goes to ovf only where listed.
- FSM states FETCH, EXEC, MEM, HALTED:
  - FETCH -> EXEC: always.
  - EXEC, non-memory op: retire, then -> FETCH. HALT retires -> HALTED.
  - EXEC, LDM/STM: latch dmem_addr = R[r], dmem_we and dmem_wdata = ACC, then -> MEM.
  - MEM: dmem_req = 1. On dmem_ack, load writes ACC from dmem_rdata, retire, -> FETCH. Otherwise stay in MEM.
  - HALTED: absorbing until start.
- Retire: PC = branch target if taken, else PC + 1 (wraps 2^PCW-1 -> 0). instr_ct + 1.
- imem_addr is held at PC through EXEC and MEM, so imem_data stays stable.
- cycle_ct increments in FETCH, EXEC and MEM. Both counters saturate at 2^CW-1.
- Halt = (state == HALTED). dmem_req = (state == MEM). Both are decoded from registered state.

## Timing
- Reset (start = 1 at an edge) sets:
  - state = FETCH, PC = 0.
  - ACC, ovf, all R[*], dmem latches = 0.
  - counters = 0.
  - Outputs from the next cycle: Halt = 0, dmem_req = 0, imem_addr = 0.
- start has priority over every event, including dmem_ack in the same cycle (that transfer is discarded).
- start during MEM drops dmem_req the cycle after start is sampled.
- Latency: non-memory instruction 2 cycles. Memory instruction 2 + k cycles, where k ≥ 1 is the number of MEM cycles up to and including the ack cycle. An ack in the first MEM cycle gives 3 cycles.
- dmem_addr, dmem_we and dmem_wdata are stable for the whole request. The load result is visible on acc_out the cycle after the ack.
- A branch target takes effect at the next FETCH. No delay slot.

## Structure
- acc_core_pkg: opcode enum (5-bit), state enum, and the IW/RW derivation function.
- Sub-module acc_alu: combinational. Inputs op, ACC, operand, ovf_in, r. Outputs result, ovf_out, acc_we, ovf_we.
- The register file, FSM, PC and counters stay in acc_core.

## Test plan
- Reset: hold start 2 cycles -> Halt = 0, imem_addr = 0, dmem_req = 0, cycle_ct = instr_ct = 0, acc_out = 0.
- Program LDI 5; STR R1; LDI 7; ADD R1; HALT -> acc_out = 0x0C, ovf = 0, instr_ct = 5, cycle_ct = 10, Halt = 1 and stays high.
- Build ACC = 0xF0 (LDI 15, SHL x4), R2 = 0x20, ADD R2 -> ACC = 0x10, ovf = 1. Then ADC R0 (R0 = 0) -> ACC = 0x11, ovf = 0.
- STM with R3 = 0x40, ACC = 0xA5, ack after 3 MEM cycles -> dmem_req high exactly 3 cycles, addr = 0x40, wdata = 0xA5, we = 1. Following LDM with rdata = 0x5A and same-cycle ack -> ACC = 0x5A, instruction takes 3 cycles.
- BZ with ACC = 0, R4 = 0x20 -> next imem_addr = 0x20. Same with ACC = 1 -> PC + 1. NOP at PC 0xFF -> next fetch 0x00.
- start asserted in the second cycle of a MEM wait, with ack in that same cycle -> ACC unchanged (0), instr_ct = 0, dmem_req low the next cycle, fetch restarts at 0.
